// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects RAW data hazards against E/M producers and
// multiply/divide unit occupancy, freezes PC/IF-ID and bubbles ID/EX on stall.

module hazard_src (
    input  logic [4:0] src_reg,
    input  logic [1:0] tuse,
    input  logic       grf_we_E,
    input  logic [4:0] grf_rd_E,
    input  logic [1:0] tnew_E,
    input  logic       grf_we_M,
    input  logic [4:0] grf_rd_M,
    input  logic [1:0] tnew_M,
    output logic       hz
);
    logic w_used;
    logic w_hit_E;
    logic w_hit_M;

    // $zero is hardwired, and tuse==3 means the operand is never read.
    assign w_used  = (src_reg != 5'd0) && (tuse != 2'd3);
    assign w_hit_E = grf_we_E && (grf_rd_E == src_reg) && (tnew_E > tuse);
    assign w_hit_M = grf_we_M && (grf_rd_M == src_reg) && (tnew_M > tuse);
    assign hz      = w_used && (w_hit_E || w_hit_M);
endmodule

module hazard_ctrl #(
    parameter int NUM_SRC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        grf_we_E,
    input  logic [4:0]  grf_rd_E,
    input  logic [1:0]  tnew_E,
    input  logic        grf_we_M,
    input  logic [4:0]  grf_rd_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_D,
    input  logic        md_div_D,
    input  logic        md_use_D,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_stop,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);
    localparam logic [3:0] MD_LAT_MUL = 4'd5;
    localparam logic [3:0] MD_LAT_DIV = 4'd10;

    logic [NUM_SRC-1:0][4:0] w_src_reg;
    logic [NUM_SRC-1:0][1:0] w_src_tuse;
    logic [NUM_SRC-1:0]      w_src_hz;

    logic        w_data_stall;
    logic        w_md_stall;
    logic        w_stall;
    logic [3:0]  r_md_cnt;
    logic [15:0] r_stall_cnt;

    assign w_src_reg  = {rt_D, rs_D};
    assign w_src_tuse = {tuse_rt_D, tuse_rs_D};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src u_src (
            .src_reg  (w_src_reg[g]),
            .tuse     (w_src_tuse[g]),
            .grf_we_E (grf_we_E),
            .grf_rd_E (grf_rd_E),
            .tnew_E   (tnew_E),
            .grf_we_M (grf_we_M),
            .grf_rd_M (grf_rd_M),
            .tnew_M   (tnew_M),
            .hz       (w_src_hz[g])
        );
    end

    assign w_data_stall = |w_src_hz;
    assign md_busy      = (r_md_cnt != 4'd0);
    assign w_md_stall   = (md_start_D || md_use_D) && md_busy;
    assign w_stall      = w_data_stall || w_md_stall;

    assign pc_en     = ~w_stall;
    assign ifid_en   = ~w_stall;
    assign idex_stop = w_stall;
    assign stall_cnt = r_stall_cnt;

    // A start can only issue unstalled, which implies the counter is already 0,
    // so load and decrement never compete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= 4'd0;
        end else if (md_start_D && !w_stall) begin
            r_md_cnt <= md_div_D ? MD_LAT_DIV : MD_LAT_MUL;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the stall rules.

module tb_hazard_ctrl;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_D, rt_D;
    logic [1:0]  tuse_rs_D, tuse_rt_D;
    logic        grf_we_E, grf_we_M;
    logic [4:0]  grf_rd_E, grf_rd_M;
    logic [1:0]  tnew_E, tnew_M;
    logic        md_start_D, md_div_D, md_use_D;
    logic        pc_en, ifid_en, idex_stop, md_busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_md_rem = 0;
    int m_scnt   = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .grf_we_E   (grf_we_E),
        .grf_rd_E   (grf_rd_E),
        .tnew_E     (tnew_E),
        .grf_we_M   (grf_we_M),
        .grf_rd_M   (grf_rd_M),
        .tnew_M     (tnew_M),
        .md_start_D (md_start_D),
        .md_div_D   (md_div_D),
        .md_use_D   (md_use_D),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_stop  (idex_stop),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles until the freshest in-flight value of r becomes available (0 = now).
    function automatic int ready_in(input logic [4:0] r);
        int e, m;
        e = (grf_we_E && grf_rd_E == r) ? int'(tnew_E) : 0;
        m = (grf_we_M && grf_rd_M == r) ? int'(tnew_M) : 0;
        return (e > m) ? e : m;
    endfunction

    function automatic bit src_waits(input logic [4:0] r, input logic [1:0] tuse);
        if (r == 5'd0 || tuse == 2'd3) return 1'b0;
        return ready_in(r) > int'(tuse);
    endfunction

    function automatic bit m_data_stall();
        return src_waits(rs_D, tuse_rs_D) || src_waits(rt_D, tuse_rt_D);
    endfunction

    function automatic bit m_stall();
        return m_data_stall() || ((md_start_D || md_use_D) && m_md_rem > 0);
    endfunction

    // Advance one clock; model captures pre-edge inputs then applies the edge.
    task automatic tick();
        bit s, st, dv;
        s  = m_stall();
        st = md_start_D;
        dv = md_div_D;
        @(posedge clk);
        if (rst_n) begin
            if (st && !s)          m_md_rem = dv ? 10 : 5;
            else if (m_md_rem > 0) m_md_rem--;
            if (s && m_scnt < 65535) m_scnt++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3;
        grf_we_E = 0; grf_rd_E = 0; tnew_E = 0;
        grf_we_M = 0; grf_rd_M = 0; tnew_M = 0;
        md_start_D = 0; md_div_D = 0; md_use_D = 0;
    endtask

    task automatic drain_md();
        idle_inputs();
        for (int i = 0; i < 20 && m_md_rem > 0; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", md_busy); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", stall_cnt); end
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL reset_pc_en got=%0b exp=1", pc_en); end
        // data hazard during reset still stalls combinationally, counter frozen
        grf_we_E = 1; grf_rd_E = 7; tnew_E = 2; rs_D = 7; tuse_rs_D = 0;
        md_start_D = 1; md_use_D = 1;
        tick(); tick();
        #1;
        checks++; if (idex_stop !== 1'b1 || pc_en !== 1'b0) begin errors++; $display("FAIL reset_data_stall got=%0b/%0b exp=1/0", idex_stop, pc_en); end
        checks++; if (stall_cnt !== 16'd0 || md_busy !== 1'b0) begin errors++; $display("FAIL reset_frozen got=%0h/%0b exp=0/0", stall_cnt, md_busy); end
        idle_inputs();
        #2 rst_n = 1;
        tick();
    endtask

    task automatic test_lw_use();
        idle_inputs();
        grf_we_E = 1; grf_rd_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1;
        #2;
        checks++; if ({pc_en, ifid_en, idex_stop} !== 3'b001) begin errors++; $display("FAIL lw_use_stall got=%b exp=001", {pc_en, ifid_en, idex_stop}); end
        tick();
        grf_we_E = 0; grf_we_M = 1; grf_rd_M = 8; tnew_M = 1;
        #2;
        checks++; if ({pc_en, ifid_en, idex_stop} !== 3'b110) begin errors++; $display("FAIL lw_use_release got=%b exp=110", {pc_en, ifid_en, idex_stop}); end
        checks++; if (stall_cnt !== 16'(m_scnt)) begin errors++; $display("FAIL lw_use_cnt got=%0d exp=%0d", stall_cnt, m_scnt); end
        tick();
    endtask

    task automatic test_operand_gating();
        idle_inputs();
        grf_we_E = 1; grf_rd_E = 0; tnew_E = 2; rs_D = 0; tuse_rs_D = 0;
        #2;
        checks++; if (idex_stop !== 1'b0 || pc_en !== 1'b1) begin errors++; $display("FAIL zero_reg got=%0b/%0b exp=0/1", idex_stop, pc_en); end
        rs_D = 0; tuse_rs_D = 3; grf_rd_E = 5; rt_D = 5; tuse_rt_D = 3;
        #2;
        checks++; if (idex_stop !== 1'b0) begin errors++; $display("FAIL unused_rt got=%0b exp=0", idex_stop); end
        tuse_rt_D = 0;
        #2;
        checks++; if (idex_stop !== 1'b1) begin errors++; $display("FAIL used_rt got=%0b exp=1", idex_stop); end
        tuse_rt_D = 2;
        #2;
        checks++; if (idex_stop !== 1'b0) begin errors++; $display("FAIL tnew_eq_tuse got=%0b exp=0", idex_stop); end
        idle_inputs();
        tick();
    endtask

    task automatic test_multiply();
        int busy_cycles;
        drain_md();
        md_start_D = 1; md_div_D = 0;
        #2;
        checks++; if (idex_stop !== 1'b0) begin errors++; $display("FAIL mult_issue got=%0b exp=0", idex_stop); end
        tick();
        md_start_D = 0; md_use_D = 1;
        busy_cycles = 0;
        for (int i = 0; i < 12 && md_busy; i++) begin
            #2;
            checks++; if (idex_stop !== 1'b1) begin errors++; $display("FAIL mult_use_stall cyc=%0d got=%0b exp=1", i, idex_stop); end
            busy_cycles++;
            tick();
        end
        checks++; if (busy_cycles != 5) begin errors++; $display("FAIL mult_busy_len got=%0d exp=5", busy_cycles); end
        #2;
        checks++; if (idex_stop !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL mult_release got=%0b/%0b exp=0/0", idex_stop, md_busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        drain_md();
        md_start_D = 1; md_div_D = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++; if (idex_stop !== 1'b1) begin errors++; $display("FAIL b2b_hold cyc=%0d got=%0b exp=1", i, idex_stop); end
            tick();
        end
        #2;
        checks++; if (idex_stop !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL b2b_reissue got=%0b/%0b exp=0/0", idex_stop, md_busy); end
        tick();
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_reload got=%0b exp=1", md_busy); end
        idle_inputs();
        drain_md();
    endtask

    task automatic test_data_blocks_start();
        int busy_cycles;
        drain_md();
        md_start_D = 1; md_div_D = 1;
        grf_we_E = 1; grf_rd_E = 3; tnew_E = 2; rs_D = 3; tuse_rs_D = 0;
        tick();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL blocked_start got=%0b exp=0", md_busy); end
        grf_we_E = 0;
        tick();
        md_start_D = 0;
        busy_cycles = 0;
        for (int i = 0; i < 20 && md_busy; i++) begin busy_cycles++; tick(); end
        checks++; if (busy_cycles != 10) begin errors++; $display("FAIL div_busy_len got=%0d exp=10", busy_cycles); end
        idle_inputs();
    endtask

    task automatic test_div_reset();
        drain_md();
        md_start_D = 1; md_div_D = 1;
        tick();
        md_start_D = 0; md_use_D = 1;
        tick(); tick(); tick();
        checks++; if (md_busy !== 1'b1 || stall_cnt === 16'd0) begin errors++; $display("FAIL div_pre_reset got=%0b/%0d exp=1/nonzero", md_busy, stall_cnt); end
        #2 rst_n = 0;
        m_md_rem = 0; m_scnt = 0;
        #1;
        checks++; if (md_busy !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL div_async_reset got=%0b/%0d exp=0/0", md_busy, stall_cnt); end
        checks++; if (idex_stop !== 1'b0) begin errors++; $display("FAIL div_reset_stop got=%0b exp=0", idex_stop); end
        tick();
        md_use_D = 0;
        #2 rst_n = 1;
        tick(); tick();
        checks++; if (md_busy !== 1'b0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL div_after_reset got=%0b/%0d exp=0/0", md_busy, stall_cnt); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit exp_stall;
        for (int i = 0; i < 3000; i++) begin
            rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
            tuse_rs_D = 2'($urandom); tuse_rt_D = 2'($urandom);
            grf_we_E = 1'($urandom); grf_rd_E = 5'($urandom_range(0, 3)); tnew_E = 2'($urandom_range(0, 2));
            grf_we_M = 1'($urandom); grf_rd_M = 5'($urandom_range(0, 3)); tnew_M = 2'($urandom_range(0, 1));
            md_start_D = ($urandom_range(0, 7) == 0); md_div_D = 1'($urandom);
            md_use_D = ($urandom_range(0, 5) == 0);
            #2;
            exp_stall = m_stall();
            checks++;
            if ({pc_en, ifid_en, idex_stop, md_busy} !== {~exp_stall, ~exp_stall, exp_stall, m_md_rem > 0}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", i, {pc_en, ifid_en, idex_stop, md_busy},
                         {~exp_stall, ~exp_stall, exp_stall, m_md_rem > 0});
            end
            checks++;
            if (stall_cnt !== 16'(m_scnt)) begin errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_scnt); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        idle_inputs();
        grf_we_E = 1; grf_rd_E = 9; tnew_E = 2; rs_D = 9; tuse_rs_D = 0;
        for (int i = 0; i < 65540; i++) tick();
        checks++; if (stall_cnt !== 16'hFFFF || m_scnt != 65535) begin errors++; $display("FAIL sat_reach got=%0h exp=ffff", stall_cnt); end
        tick(); tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lw_use();
        test_operand_gating();
        test_multiply();
        test_back_to_back();
        test_data_blocks_start();
        test_random();
        test_div_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 Port rs_D, rt_D  in  5 each  source register numbers of instruction in D.
REQ-004 Port tuse_rs_D, tuse_rt_D  in  2 each  cycles until operand needed: 0 = in D, 1 = in E, 2 = in M, 3 = not used.
REQ-005 Port grf_we_E, grf_rd_E, tnew_E  in  1/5/2  E-stage write enable, destination, cycles until result ready (lw=2, ALU=1, else 0).
REQ-006 Port grf_we_M, grf_rd_M, tnew_M  in  1/5/2  same for M stage.
REQ-007 Port md_start_D  in  1  D holds mult/multu/div/divu.
REQ-008 Port md_div_D  in  1  1 = divide class, 0 = multiply class; valid with md_start_D.
REQ-009 Port md_use_D  in  1  D holds mfhi/mflo/mthi/mtlo.
REQ-010 Port pc_en  out  1  1 = PC may advance.
REQ-011 Port ifid_en  out  1  1 = IF/ID register may load.
REQ-012 Port idex_stop  out  1  1 = ID/EX register loads a bubble (drives its stop input).
REQ-013 Port md_busy  out  1  multiply/divide unit occupied.
REQ-014 Port stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-015 data_stall SHALL be 1 when, for rs or rt, reg != 0 and tuse != 3 and either (grf_we_E, grf_rd_E == reg, tnew_E > tuse) or (grf_we_M, grf_rd_M == reg, tnew_M > tuse).
REQ-016 Register 0 SHALL never cause a stall, whatever the E/M destinations.
REQ-017 md_busy SHALL equal (md_cnt != 0), where md_cnt is a 4-bit internal down-counter.
REQ-018 md_stall SHALL be 1 when (md_start_D or md_use_D) and md_busy.
REQ-019 stall SHALL be data_stall OR md_stall; combinational, same cycle as inputs, no added latency.
REQ-020 pc_en = ifid_en = NOT stall; idex_stop = stall.
REQ-021 md_cnt SHALL load 10 (md_div_D=1) or 5 (md_div_D=0) on a rising edge where md_start_D=1 and stall=0.
REQ-022 md_cnt SHALL otherwise decrement by 1 per cycle while nonzero and hold at 0.
REQ-023 Load SHALL take priority over decrement: start issued on the last busy cycle is stalled per REQ-018, so load occurs only from md_cnt = 0.
REQ-024 A start blocked by data_stall SHALL NOT load md_cnt; the counter loads on the first unstalled cycle.
REQ-025 stall_cnt SHALL increment on each rising edge where stall=1, saturate at 0xFFFF, never wrap.
REQ-026 Simultaneous data_stall and md_stall SHALL count as one stall cycle.

Reset
REQ-027 rst_n=0 SHALL immediately clear md_cnt and stall_cnt to 0, independent of clk.
REQ-028 During and after reset, md_busy=0 and md_stall=0; pc_en, ifid_en, idex_stop follow data_stall combinationally.
REQ-029 Reset asserted mid-multiply/divide SHALL abort it: md_busy=0 on deassertion, no residual count.
REQ-030 State SHALL resume updating on the first rising clk after rst_n returns to 1.

Verification
REQ-031 lw-use: grf_we_E=1, grf_rd_E=8, tnew_E=2; rs_D=8, tuse_rs_D=1 -> pc_en=0, ifid_en=0, idex_stop=1; next cycle tnew_M=1, tuse 1 -> stall released; stall_cnt +1.
REQ-032 Zero register: grf_we_E=1, grf_rd_E=0, tnew_E=2; rs_D=0, tuse_rs_D=0 -> stall=0, pc_en=1.
REQ-033 Unused operand: hazard match on rt_D=5 with tuse_rt_D=3 -> stall=0.
REQ-034 Multiply: md_start_D=1, md_div_D=0, no data hazard -> md_busy=1 for exactly 5 cycles; md_use_D=1 during those cycles -> idex_stop=1; released on cycle 6.
REQ-035 Divide with reset: issue div (md_cnt=10), drop rst_n after 3 cycles -> md_busy=0 and stall_cnt=0 immediately, before next edge.
REQ-036 Saturation: hold stall=1 for 65 540 cycles -> stall_cnt=0xFFFF, stays 0xFFFF.
